alu_ctrl: RTL
=============

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, data width of operand, accumulator and ALU ports.
REQ-002 Parameter ALU_LAT, default 1, cycles from ALU input drive to result capture; legal range 1..7.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command this cycle.
REQ-007 cmd_op  input  3  ALU operation code, forwarded unmodified.
REQ-008 cmd_data  input  WIDTH  operand for ALU bus input, or AC load value.
REQ-009 cmd_ldac  input  1  1 = load AC directly from cmd_data, ALU bypassed.
REQ-010 alu_bus  output  WIDTH  drives ALU in_bus.
REQ-011 alu_ac  output  WIDTH  drives ALU in_AC.
REQ-012 alu_op  output  3  drives ALU operation.
REQ-013 alu_result  input  WIDTH  ALU data_out.
REQ-014 ac_out  output  WIDTH  current accumulator (AC) value.
REQ-015 busy  output  1  command in progress.
REQ-016 done  output  1  one-cycle pulse, command retired, AC updated.

Function
REQ-017 States SHALL be IDLE, EXEC, CAPTURE; IDLE is the only state with cmd_ready=1.
REQ-018 Accept SHALL occur on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_valid while cmd_ready=0 SHALL be ignored, no queuing.
REQ-019 Accepted cmd_ldac=1: AC <= cmd_data at the accept edge, done=1 the following cycle, state stays IDLE (back-to-back accepts allowed).
REQ-020 Accepted cmd_ldac=0: alu_bus <= cmd_data, alu_op <= cmd_op, alu_ac <= AC at the accept edge; state -> EXEC; latency counter loaded with ALU_LAT-1.
REQ-021 EXEC: counter decrements each cycle; at zero state -> CAPTURE.
REQ-022 CAPTURE edge: AC <= alu_result, state -> IDLE, done=1 the following cycle.
REQ-023 Accept-to-capture SHALL be exactly ALU_LAT edges; accept-to-next-accept minimum ALU_LAT+1 edges; done coincides with cmd_ready=1.
REQ-024 alu_bus, alu_ac, alu_op SHALL hold stable from accept until the capture edge and retain last values in IDLE.
REQ-025 busy = 1 in EXEC and CAPTURE, else 0.
REQ-026 Result SHALL be captured full WIDTH, no sign extension, truncation or saturation; wrap-around belongs to the ALU.
REQ-027 ac_out SHALL equal AC register at all times; AC changes only at REQ-019, REQ-022 or reset.
REQ-028 done SHALL never be asserted two consecutive cycles for one command.

Reset
REQ-029 rst=1 at an edge: state IDLE, AC=0, ac_out=0, alu_bus=0, alu_ac=0, alu_op=0, counter=0, busy=0, done=0, cmd_ready=0 during the reset cycle.
REQ-030 rst overrides any simultaneous accept; reset mid-command SHALL abort it with no AC update and no done pulse.
REQ-031 cmd_ready SHALL be 1 on the first cycle after rst deasserts.

Verification (bench ALU model: op0 = bus+AC, op1 = AC-bus, op2 = AC&bus, op3 = AC|bus, op4 = AC^bus, op5 = bus, registered result delay matching ALU_LAT)
REQ-032 ldac 5, then op0 data 2 -> alu_bus=2, alu_ac=5, alu_op=0 held; ac_out=7 after ALU_LAT edges; single done pulse.
REQ-033 AC=5, ops 1..5 with data 2 back-to-back, cmd_valid held high -> ac_out sequence 3, 2, 2, 0, 2; each accept exactly ALU_LAT+1 edges apart.
REQ-034 AC=16'hFFFF, op0 data 1 -> ac_out=16'h0000, no other output disturbed.
REQ-035 cmd_valid pulsed while busy=1 -> command dropped, AC and ALU outputs unchanged, no extra done.
REQ-036 rst asserted in EXEC (ALU_LAT=4, after 2 edges) -> next cycle all outputs 0, no done; fresh ldac 9 -> ac_out=9.
REQ-037 Repeat REQ-032..REQ-036 with ALU_LAT=1 and ALU_LAT=7.

Source files
------------

// File: rtl/alu_ctrl.sv
// Sequencer between a command port and an external ALU with a fixed pipeline latency.
// It owns the accumulator (AC): either loads it directly or runs one ALU operation and captures the result.
module alu_ctrl #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_ldac,
  output logic [WIDTH-1:0] alu_bus,
  output logic [WIDTH-1:0] alu_ac,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] ac_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
  // are both 1. cmd_ready is high only in IDLE and outside reset; cmd_valid seen
  // while cmd_ready is low is ignored and never queued.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT - 1);

  state_t           state;
  logic [2:0]       lat_cnt;
  logic [WIDTH-1:0] ac_q;
  logic             accept;

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign ac_out    = ac_q;
  assign fsm_state = state;

  // The counter reaching zero moves the FSM to CAPTURE, so the capture edge lands
  // exactly ALU_LAT edges after accept; with ALU_LAT=1 EXEC is skipped entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      lat_cnt <= 3'd0;
      ac_q    <= '0;
      alu_bus <= '0;
      alu_ac  <= '0;
      alu_op  <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_ldac) begin
              ac_q <= cmd_data;
              done <= 1'b1;
            end else begin
              alu_bus <= cmd_data;
              alu_op  <= cmd_op;
              alu_ac  <= ac_q;
              lat_cnt <= LAT_LOAD;
              busy    <= 1'b1;
              state   <= (LAT_LOAD == 3'd0) ? ST_CAPTURE : ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt <= 3'd1) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          ac_q  <= alu_result;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
